word_assembler: RTL

//  Parametrised byte-to-word packer for the AES datapath (key expansion, S-box return path).

---
 rtl/aes_pkg.sv | 9 +
 rtl/word_assembler.sv | 87 ++++++++
 2 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: AES datapath widths and RotWord helper shared by the byte/word packers.
package aes_pkg;
    localparam int AES_BYTE_W = 8;
    localparam int AES_WORD_W = 32;

    function automatic logic [AES_WORD_W-1:0] rot_word(input logic [AES_WORD_W-1:0] w);
        return {w[AES_WORD_W-AES_BYTE_W-1:0], w[AES_WORD_W-1 -: AES_BYTE_W]};
    endfunction
endpackage

// File: rtl/word_assembler.sv
// word_assembler: MSB-first byte-to-word packer with registered valid/ready output.
// Define ASM_ROTWORD_EN to add the rot input and emit RotWord-rotated words.
import aes_pkg::*;

module word_assembler #(
    parameter int BYTE_W         = AES_BYTE_W,
    parameter int BYTES_PER_WORD = AES_WORD_W / AES_BYTE_W,
    localparam int WORD_W        = BYTE_W * BYTES_PER_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              clear,
`ifdef ASM_ROTWORD_EN
    input  logic              rot,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic              busy
);
    localparam int IW = $clog2(BYTES_PER_WORD);
    localparam logic [IW-1:0] LAST = IW'(BYTES_PER_WORD - 1);

    logic [IW-1:0]     idx;
    logic [WORD_W-1:0] acc, merged, done;
    logic              xfer;

    assign in_ready = (idx != LAST) || !out_valid || out_ready;
    assign xfer     = in_valid && in_ready && !clear;
    assign busy     = idx != '0;

    for (genvar g = 0; g < BYTES_PER_WORD; g++) begin : g_lane
        assign merged[WORD_W-1-g*BYTE_W -: BYTE_W] =
            (xfer && idx == IW'(g)) ? in_byte : acc[WORD_W-1-g*BYTE_W -: BYTE_W];
    end

`ifdef ASM_ROTWORD_EN
    logic              rot_q;
    logic [WORD_W-1:0] rotated;
    if (WORD_W == AES_WORD_W) begin : g_aes_rot
        assign rotated = rot_word(merged);
    end else begin : g_gen_rot
        assign rotated = {merged[WORD_W-BYTE_W-1:0], merged[WORD_W-1 -: BYTE_W]};
    end
    assign done = rot_q ? rotated : merged;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rot_q <= 1'b0;
        else if (clear)
            rot_q <= 1'b0;
        else if (xfer && idx == '0)
            rot_q <= rot;
    end
`else
    assign done = merged;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx       <= '0;
            acc       <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (clear) begin
                idx <= '0;
                acc <= '0;
            end else if (xfer) begin
                if (idx == LAST) begin
                    out_word  <= done;
                    out_valid <= 1'b1;
                    idx       <= '0;
                    acc       <= '0;
                end else begin
                    acc <= merged;
                    idx <= idx + IW'(1);
                end
            end
        end
    end
endmodule
